// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, ps2_clk falling-edge detect, bit FSM,
// odd-parity check and mid-frame timeout. Emits one byte per good frame.
// Parity enforcement is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_err,
  output logic       o_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_clkSync;
  logic [SYNC_STAGES-1:0] r_dataSync;
  logic                   r_clkPrev;
  ps2_state_t             r_state;
  logic [2:0]             r_bitCnt;
  logic [7:0]             r_shift;
  logic                   r_parity;
  logic [TW-1:0]          r_tmoCnt;
  logic                   r_byteValid;
  logic                   r_err;
  logic                   r_timeout;

  ps2_state_t             w_stateNxt;
  logic [2:0]             w_bitCntNxt;
  logic [7:0]             w_shiftNxt;
  logic                   w_parityNxt;
  logic [TW-1:0]          w_tmoCntNxt;
  logic                   w_doneNxt;
  logic                   w_errNxt;
  logic                   w_tmoNxt;
  logic                   w_clkS;
  logic                   w_dataS;
  logic                   w_fall;
  logic                   w_parityCalc;
  logic                   w_parityOk;

  assign w_clkS       = r_clkSync[SYNC_STAGES-1];
  assign w_dataS      = r_dataSync[SYNC_STAGES-1];
  assign w_fall       = r_clkPrev & ~w_clkS;
  assign w_parityCalc = ^{r_shift, r_parity};

`ifdef PS2_PARITY_CHECK_EN
  assign w_parityOk = w_parityCalc;
`else
  // Parity bit is still captured but never blocks a frame in this build.
  assign w_parityOk = w_parityCalc | 1'b1;
`endif

  // Synchronize both raw pins (idle-high) and remember last sync'd clock level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clkSync  <= '1;
      r_dataSync <= '1;
      r_clkPrev  <= 1'b1;
    end else begin
      r_clkSync  <= {r_clkSync[SYNC_STAGES-2:0], i_ps2_clk};
      r_dataSync <= {r_dataSync[SYNC_STAGES-2:0], i_ps2_data};
      r_clkPrev  <= w_clkS;
    end
  end

  // Bit FSM state and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_tmoCnt    <= '0;
      r_byteValid <= 1'b0;
      r_err       <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_stateNxt;
      r_bitCnt    <= w_bitCntNxt;
      r_shift     <= w_shiftNxt;
      r_parity    <= w_parityNxt;
      r_tmoCnt    <= w_tmoCntNxt;
      r_byteValid <= w_doneNxt;
      r_err       <= w_errNxt;
      r_timeout   <= w_tmoNxt;
    end
  end

  // One FSM step per ps2_clk falling edge; otherwise run the mid-frame timeout.
  always_comb begin
    w_stateNxt  = r_state;
    w_bitCntNxt = r_bitCnt;
    w_shiftNxt  = r_shift;
    w_parityNxt = r_parity;
    w_tmoCntNxt = r_tmoCnt;
    w_doneNxt   = 1'b0;
    w_errNxt    = 1'b0;
    w_tmoNxt    = 1'b0;
    if (w_fall) begin
      w_tmoCntNxt = '0;
      case (r_state)
        IDLE: begin
          if (!w_dataS) begin
            w_stateNxt  = DATA;
            w_bitCntNxt = '0;
          end
        end
        DATA: begin
          w_shiftNxt  = {w_dataS, r_shift[7:1]};
          w_bitCntNxt = r_bitCnt + 3'd1;
          if (r_bitCnt == 3'd7) begin
            w_stateNxt = PARITY;
          end
        end
        PARITY: begin
          w_parityNxt = w_dataS;
          w_stateNxt  = STOP;
        end
        STOP: begin
          w_stateNxt = IDLE;
          if (w_dataS && w_parityOk) begin
            w_doneNxt = 1'b1;
          end else begin
            w_errNxt = 1'b1;
          end
        end
        default: w_stateNxt = IDLE;
      endcase
    end else if (r_state != IDLE) begin
      if (r_tmoCnt == TMO_LAST) begin
        w_stateNxt  = IDLE;
        w_tmoCntNxt = '0;
        w_errNxt    = 1'b1;
        w_tmoNxt    = 1'b1;
      end else begin
        w_tmoCntNxt = r_tmoCnt + 1'b1;
      end
    end
  end

  assign o_byte       = r_shift;
  assign o_byte_valid = r_byteValid;
  assign o_err        = r_err;
  assign o_timeout    = r_timeout;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard scancode receiver: turns raw PS/2 frames into one make code per
// key press, filtering break (F0) sequences and tagging E0-extended codes.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity rejection of frames.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic [7:0] keypress_out,
  output logic       keypress_valid,
  output logic       extended_out,
  output logic       frame_err_out
);

  logic [7:0] w_byte;
  logic       w_byteValid;
  logic       w_err;
  logic       w_timeout;

  logic [7:0] r_keypress;
  logic       r_valid;
  logic       r_extended;
  logic       r_frameErr;
  logic       r_breakPend;
  logic       r_extPend;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame (
    .i_clk       (clk_in),
    .i_rst_n     (rst_n_in),
    .i_ps2_clk   (ps2_clk_in),
    .i_ps2_data  (ps2_data_in),
    .o_byte      (w_byte),
    .o_byte_valid(w_byteValid),
    .o_err       (w_err),
    .o_timeout   (w_timeout)
  );

  // Byte layer: track F0/E0 prefixes and publish make codes one cycle after byte done.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_keypress  <= '0;
      r_valid     <= 1'b0;
      r_extended  <= 1'b0;
      r_frameErr  <= 1'b0;
      r_breakPend <= 1'b0;
      r_extPend   <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_frameErr <= w_err;
      if (w_timeout) begin
        r_breakPend <= 1'b0;
        r_extPend   <= 1'b0;
      end else if (w_byteValid) begin
        if (w_byte == PS2_BREAK) begin
          r_breakPend <= 1'b1;
        end else if (w_byte == PS2_EXT) begin
          r_extPend <= 1'b1;
        end else if (r_breakPend) begin
          r_breakPend <= 1'b0;
          r_extPend   <= 1'b0;
        end else begin
          r_keypress <= w_byte;
          r_extended <= r_extPend;
          r_valid    <= 1'b1;
          r_extPend  <= 1'b0;
        end
      end
    end
  end

  assign keypress_out   = r_keypress;
  assign keypress_valid = r_valid;
  assign extended_out   = r_extended;
  assign frame_err_out  = r_frameErr;

endmodule
